// File: rtl/serial_multiplier_param.sv
// ---------------------------------------------------------------------------
// serial_multiplier_param
//
// Parametrised shift-add serial multiplier with per-operation signed/unsigned
// mode, optional early termination once the remaining multiplier bits are all
// zero, multiply-accumulate into the result register, and a busy flag.
//
// One multiplier bit is consumed per cycle, LSB first. Signed operands are
// converted to magnitudes on entry and the product is negated at the end, so
// the core datapath is purely unsigned.
//
// Parameters
//   WIDTH      operand width (>= 2); result width is 2*WIDTH
//   SKIP_ZERO  1: stop once remaining multiplier magnitude bits are zero
//              0: always run WIDTH iterations
//
// Ports
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   en         start pulse, sampled only while idle (busy = 0)
//   is_signed  1: A and B are two's complement (latched with en)
//   acc_en     1: S <= S + A*B, 0: S <= A*B (latched with en)
//   A          multiplicand (latched with en)
//   B          multiplier (latched with en)
//   busy       operation in progress
//   valid      one-cycle pulse, S/ovf just updated
//   S          result, held until the next completed operation or reset
//   ovf        accumulate wrapped, held with S
// ---------------------------------------------------------------------------
module serial_multiplier_param #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned SKIP_ZERO = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 is_signed,
    input  logic                 acc_en,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    output logic                 busy,
    output logic                 valid,
    output logic [2*WIDTH-1:0]   S,
    output logic                 ovf
);

    localparam int unsigned PW = 2 * WIDTH;
    localparam int unsigned CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        StIdle,
        StCalc,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [PW-1:0]     mcand_q, mcand_d;     // multiplicand, pre-shifted by bit index
    logic [WIDTH-1:0]  mplier_q, mplier_d;   // remaining multiplier bits, LSB = current
    logic [PW-1:0]     partial_q, partial_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              neg_q, neg_d;         // product sign
    logic              sgn_q, sgn_d;         // signed mode, selects ovf rule
    logic              acc_q, acc_d;
    logic [PW-1:0]     s_q, s_d;
    logic              ovf_q, ovf_d;
    logic              valid_q, valid_d;

    // Operand magnitudes; |-2^(WIDTH-1)| = 2^(WIDTH-1) still fits in WIDTH bits.
    logic [WIDTH-1:0]  a_mag, b_mag;
    logic [PW-1:0]     prod;
    logic [PW:0]       sum_ext;
    logic              ovf_calc;
    logic              last_iter;

    always_comb begin
        a_mag = (is_signed && A[WIDTH-1]) ? (~A + WIDTH'(1)) : A;
        b_mag = (is_signed && B[WIDTH-1]) ? (~B + WIDTH'(1)) : B;
    end

    // Final product and accumulate; only meaningful while in StDone.
    always_comb begin
        prod     = neg_q ? (~partial_q + PW'(1)) : partial_q;
        sum_ext  = {1'b0, s_q} + {1'b0, prod};
        ovf_calc = 1'b0;
        if (acc_q) begin
            if (sgn_q) begin
                // Two's-complement overflow: like-signed addends, result sign differs.
                ovf_calc = (s_q[PW-1] == prod[PW-1]) && (sum_ext[PW-1] != s_q[PW-1]);
            end else begin
                ovf_calc = sum_ext[PW];
            end
        end
    end

    // Iteration ends at WIDTH bits, or early when no set bits remain above the
    // current one. The current bit is always processed, so N >= 1.
    always_comb begin
        last_iter = (cnt_q == CW'(WIDTH - 1));
        if ((SKIP_ZERO != 0) && ((mplier_q >> 1) == '0)) begin
            last_iter = 1'b1;
        end
    end

    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        partial_d = partial_q;
        cnt_d     = cnt_q;
        neg_d     = neg_q;
        sgn_d     = sgn_q;
        acc_d     = acc_q;
        s_d       = s_q;
        ovf_d     = ovf_q;
        valid_d   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (en) begin
                    mcand_d   = {{WIDTH{1'b0}}, a_mag};
                    mplier_d  = b_mag;
                    partial_d = '0;
                    cnt_d     = '0;
                    neg_d     = is_signed && (A[WIDTH-1] ^ B[WIDTH-1]);
                    sgn_d     = is_signed;
                    acc_d     = acc_en;
                    state_d   = StCalc;
                end
            end
            StCalc: begin
                if (mplier_q[0]) begin
                    partial_d = partial_q + mcand_q;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CW'(1);
                if (last_iter) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                s_d     = acc_q ? sum_ext[PW-1:0] : prod;
                ovf_d   = ovf_calc;
                valid_d = 1'b1;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            mcand_q   <= '0;
            mplier_q  <= '0;
            partial_q <= '0;
            cnt_q     <= '0;
            neg_q     <= 1'b0;
            sgn_q     <= 1'b0;
            acc_q     <= 1'b0;
            s_q       <= '0;
            ovf_q     <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            partial_q <= partial_d;
            cnt_q     <= cnt_d;
            neg_q     <= neg_d;
            sgn_q     <= sgn_d;
            acc_q     <= acc_d;
            s_q       <= s_d;
            ovf_q     <= ovf_d;
            valid_q   <= valid_d;
        end
    end

    assign busy  = (state_q != StIdle);
    assign valid = valid_q;
    assign S     = s_q;
    assign ovf   = ovf_q;

endmodule

// File: tb/tb_serial_multiplier_param.sv
// ---------------------------------------------------------------------------
// Testbench for serial_multiplier_param (WIDTH = 8). Two instances share all
// inputs: one with SKIP_ZERO = 1, one with SKIP_ZERO = 0. A driver pushes the
// expected result and latency into one queue per instance; a monitor per
// instance pops and compares whenever that instance pulses valid.
// ---------------------------------------------------------------------------
module tb_serial_multiplier_param;

    localparam int W = 8;

    typedef struct {
        logic [2*W-1:0] s;
        logic           ovf;
        int             issue;
        int             lat_s;
        int             lat_f;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           en = 1'b0;
    logic           is_signed = 1'b0;
    logic           acc_en = 1'b0;
    logic [W-1:0]   A = '0;
    logic [W-1:0]   B = '0;

    logic           busy_s, valid_s, ovf_s;
    logic [2*W-1:0] s_s;
    logic           busy_f, valid_f, ovf_f;
    logic [2*W-1:0] s_f;

    exp_t           q_s[$];
    exp_t           q_f[$];
    int             checks = 0;
    int             failures = 0;
    int             cyc = 0;
    logic [2*W-1:0] model_s = '0;

    serial_multiplier_param #(.WIDTH(W), .SKIP_ZERO(1)) dut_skip (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .is_signed (is_signed),
        .acc_en    (acc_en),
        .A         (A),
        .B         (B),
        .busy      (busy_s),
        .valid     (valid_s),
        .S         (s_s),
        .ovf       (ovf_s)
    );

    serial_multiplier_param #(.WIDTH(W), .SKIP_ZERO(0)) dut_full (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .is_signed (is_signed),
        .acc_en    (acc_en),
        .A         (A),
        .B         (B),
        .busy      (busy_f),
        .valid     (valid_f),
        .S         (s_f),
        .ovf       (ovf_f)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Iterations for SKIP_ZERO=1: max(1, highest set bit of |B| + 1).
    function automatic int skip_iters(input logic [W-1:0] b, input logic sgn);
        logic [W-1:0] mag;
        int           n;
        mag = (sgn && b[W-1]) ? (~b + 8'd1) : b;
        n = 1;
        for (int i = 0; i < W; i++) begin
            if (mag[i]) n = i + 1;
        end
        return n;
    endfunction

    // Golden model for random operations.
    task automatic model_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn,
                            input logic acc, output logic [2*W-1:0] es, output logic eo);
        logic signed [2*W-1:0] ea, eb;
        logic [2*W-1:0]        p;
        logic [2*W:0]          sum;
        if (sgn) begin
            ea = {{W{a[W-1]}}, a};
            eb = {{W{b[W-1]}}, b};
        end else begin
            ea = {{W{1'b0}}, a};
            eb = {{W{1'b0}}, b};
        end
        p   = ea * eb;
        sum = {1'b0, model_s} + {1'b0, p};
        if (!acc) begin
            es = p;
            eo = 1'b0;
        end else begin
            es = sum[2*W-1:0];
            eo = sgn ? ((model_s[2*W-1] == p[2*W-1]) && (sum[2*W-1] != model_s[2*W-1]))
                     : sum[2*W];
        end
    endtask

    // Called at a negedge while the DUTs are able to accept; returns one negedge later.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn,
                         input logic acc, input logic [2*W-1:0] es, input logic eo);
        exp_t e;
        A         = a;
        B         = b;
        is_signed = sgn;
        acc_en    = acc;
        en        = 1'b1;
        e.s       = es;
        e.ovf     = eo;
        e.issue   = cyc;
        e.lat_s   = skip_iters(b, sgn) + 1;
        e.lat_f   = W + 1;
        q_s.push_back(e);
        q_f.push_back(e);
        model_s = es;
        @(negedge clk);
        en        = 1'b0;
        A         = 8'($urandom);
        B         = 8'($urandom);
        is_signed = 1'($urandom);
        acc_en    = 1'($urandom);
    endtask

    task automatic wait_idle();
        int k = 0;
        while ((busy_s || busy_f || q_s.size() != 0 || q_f.size() != 0) && k < 40) begin
            @(negedge clk);
            k++;
        end
        check("wait_idle_timeout", 32'(k >= 40), 32'd0);
    endtask

    task automatic wait_valid_full();
        int k = 0;
        while (!valid_f && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("wait_valid_timeout", 32'(k >= 20), 32'd0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (valid_s) begin
            if (q_s.size() == 0) begin
                check("skip_spurious_valid", 32'd1, 32'd0);
            end else begin
                e = q_s.pop_front();
                check("skip_S", 32'(s_s), 32'(e.s));
                check("skip_ovf", 32'(ovf_s), 32'(e.ovf));
                check("skip_latency", 32'(cyc - e.issue - 1), 32'(e.lat_s));
                check("skip_busy_in_valid", 32'(busy_s), 32'd0);
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (valid_f) begin
            if (q_f.size() == 0) begin
                check("full_spurious_valid", 32'd1, 32'd0);
            end else begin
                e = q_f.pop_front();
                check("full_S", 32'(s_f), 32'(e.s));
                check("full_ovf", 32'(ovf_f), 32'(e.ovf));
                check("full_latency", 32'(cyc - e.issue - 1), 32'(e.lat_f));
                check("full_busy_in_valid", 32'(busy_f), 32'd0);
            end
        end
    end

    initial begin
        logic [W-1:0]   ra, rb;
        logic           rsg, rac, eo;
        logic [2*W-1:0] es;

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_S_skip", 32'(s_s), 32'd0);
        check("rst_S_full", 32'(s_f), 32'd0);
        check("rst_busy", 32'({busy_s, busy_f}), 32'd0);
        check("rst_valid", 32'({valid_s, valid_f}), 32'd0);
        check("rst_ovf", 32'({ovf_s, ovf_f}), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic unsigned and signed products, including -2^(W-1) corners.
        issue(8'd200, 8'd150, 1'b0, 1'b0, 16'h7530, 1'b0); wait_idle();
        check("hold_S", 32'(s_s), 32'h7530);
        issue(8'h80, 8'h80, 1'b1, 1'b0, 16'h4000, 1'b0); wait_idle();
        issue(8'h80, 8'h7F, 1'b1, 1'b0, 16'hC080, 1'b0); wait_idle();
        // Early termination extremes.
        issue(8'd255, 8'd0, 1'b0, 1'b0, 16'h0000, 1'b0); wait_idle();
        issue(8'd255, 8'd1, 1'b0, 1'b0, 16'h00FF, 1'b0); wait_idle();
        // Unsigned accumulate with carry out.
        issue(8'd255, 8'd255, 1'b0, 1'b0, 16'hFE01, 1'b0); wait_idle();
        issue(8'd1, 8'd1, 1'b0, 1'b1, 16'hFE02, 1'b0); wait_idle();
        issue(8'd255, 8'd2, 1'b0, 1'b1, 16'h0000, 1'b1); wait_idle();
        check("hold_ovf", 32'({ovf_s, ovf_f}), 32'h3);
        // Signed accumulate: positive overflow, then negative sums without overflow.
        issue(8'd127, 8'd127, 1'b1, 1'b0, 16'h3F01, 1'b0); wait_idle();
        issue(8'd127, 8'd127, 1'b1, 1'b1, 16'h7E02, 1'b0); wait_idle();
        issue(8'd127, 8'd127, 1'b1, 1'b1, 16'hBD03, 1'b1); wait_idle();
        issue(8'hFF, 8'd1, 1'b1, 1'b0, 16'hFFFF, 1'b0); wait_idle();
        issue(8'hFF, 8'd1, 1'b1, 1'b1, 16'hFFFE, 1'b0); wait_idle();

        // en while busy must be ignored.
        issue(8'd200, 8'd150, 1'b0, 1'b0, 16'h7530, 1'b0);
        @(negedge clk);
        check("busy_calc", 32'({busy_s, busy_f}), 32'h3);
        A = 8'd3; B = 8'd3; acc_en = 1'b1; en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        wait_idle();

        // Reset in the middle of an operation discards it.
        issue(8'd9, 8'd9, 1'b0, 1'b0, 16'h0051, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        q_s.delete();
        q_f.delete();
        @(negedge clk);
        rst_n = 1'b1;
        model_s = '0;
        check("midrst_S", 32'({s_s, s_f}), 32'd0);
        check("midrst_busy", 32'({busy_s, busy_f}), 32'd0);
        check("midrst_ovf", 32'({ovf_s, ovf_f}), 32'd0);
        repeat (12) @(negedge clk);
        check("midrst_S_after", 32'({s_s, s_f}), 32'd0);

        // Random operations, sometimes reissued in the valid cycle.
        for (int i = 0; i < 200; i++) begin
            ra  = 8'($urandom);
            rb  = 8'($urandom);
            rsg = 1'($urandom);
            rac = 1'($urandom);
            if (i % 7 == 0) rb = 8'($urandom_range(0, 3));
            if (i != 0 && $urandom_range(0, 1) == 1) wait_valid_full();
            else wait_idle();
            model_op(ra, rb, rsg, rac, es, eo);
            issue(ra, rb, rsg, rac, es, eo);
        end
        wait_idle();
        check("final_S", 32'({s_s, s_f}), 32'({model_s, model_s}));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
